mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between instruction fetch (IF) and the load/store path (MEM stage).
- Sequences each variable-latency memory transaction: arbitrates, holds the request stable until `mem_ready`, and stalls the losing or waiting requester.
- Generates store byte enables and lane-replicated write data; extracts and sign/zero-extends load data.
- Returns data to the requester for the pipeline registers downstream.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: IF vs load/store,
// with store lane steering and load extraction.
module mem_port_arbiter #(
  parameter int FETCH_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        d_misalign,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  localparam logic [3:0] SMAX = 4'(FETCH_STARVE_MAX);

  state_t      state;
  logic [3:0]  starve;
  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_sgn;

  logic        mis;
  logic        d_ok;
  logic        take_i;
  logic        take_d;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;

  always_comb begin
    mis = 1'b1;
    unique case (d_size)
      2'd0: mis = 1'b0;
      2'd1: mis = d_addr[0];
      2'd2: mis = |d_addr[1:0];
      default: mis = 1'b1;
    endcase
  end

  assign d_ok   = d_req & ~mis;
  assign take_i = (state == IDLE) & if_req
                & (~d_ok | (starve == SMAX));
  assign take_d = (state == IDLE) & d_ok & ~take_i;

  assign if_stall   = if_req & (state != DONE_I);
  assign d_stall    = d_req & (state != DONE_D) & ~mis;
  assign d_misalign = d_req & mis;

  always_comb begin
    st_be   = 4'hf;
    st_data = d_wdata;
    unique case (d_size)
      2'd0: begin
        st_be   = 4'b0001 << d_addr[1:0];
        st_data = {4{d_wdata[7:0]}};
      end
      2'd1: begin
        st_be   = d_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{d_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'hf;
        st_data = d_wdata;
      end
    endcase
  end

  // Lane select uses the offset latched at grant time
  always_comb begin
    ld_b = mem_rdata[7:0];
    unique case (ld_off)
      2'd0: ld_b = mem_rdata[7:0];
      2'd1: ld_b = mem_rdata[15:8];
      2'd2: ld_b = mem_rdata[23:16];
      default: ld_b = mem_rdata[31:24];
    endcase
    ld_h = ld_off[1] ? mem_rdata[31:16]
                     : mem_rdata[15:0];
    ld_val = mem_rdata;
    unique case (ld_size)
      2'd0: ld_val = {{24{ld_sgn & ld_b[7]}}, ld_b};
      2'd1: ld_val = {{16{ld_sgn & ld_h[15]}}, ld_h};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      starve    <= '0;
      ld_off    <= '0;
      ld_size   <= '0;
      ld_sgn    <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take_i | take_d) begin
            starve <= (take_d & if_req)
                    ? starve + 4'd1 : 4'd0;
          end
          if (take_i) begin
            state     <= BUSY_I;
            mem_valid <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'hf;
            mem_addr  <= if_addr;
          end else if (take_d) begin
            state     <= BUSY_D;
            mem_valid <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_we ? st_be : 4'hf;
            mem_addr  <= d_addr[31:2];
            mem_wdata <= st_data;
            ld_off    <= d_addr[1:0];
            ld_size   <= d_size;
            ld_sgn    <= d_signed;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if_rdata  <= mem_rdata;
            state     <= DONE_I;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (!mem_we) d_rdata <= ld_val;
            state     <= DONE_D;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random traffic against a transaction-level
// reference of the memory port arbiter.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req;
  logic [29:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        d_misalign;
  logic        mem_valid;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.FETCH_STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_size(d_size),
    .d_signed(d_signed), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_stall(d_stall), .d_misalign(d_misalign),
    .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // reference: who owns the port, and whether
  // the result is being handed back this cycle
  int          owner;
  bit          fin;
  int          scnt;
  int          l_off;
  int          l_size;
  bit          l_sgn;
  bit          l_we;
  logic        e_valid;
  logic        e_we;
  logic [3:0]  e_be;
  logic [29:0] e_addr;
  logic [31:0] e_wdata;
  logic [31:0] e_if;
  logic [31:0] e_d;
  bit          ps_if;
  bit          ps_d;
  bit          sat;
  int          grants_i;
  int          grants_d;

  function automatic bit is_mis(input logic [1:0] sz,
                                input logic [31:0] a);
    int o;
    o = int'(a % 4);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (o % 2) != 0;
    if (sz == 2'd2) return o != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(
      input logic [31:0] r, input int off,
      input int sz, input bit sg);
    longint v;
    int bits;
    if (sz == 2) return r;
    bits = (sz == 0) ? 8 : 16;
    if (sz == 1) off = off - (off % 2);
    v = (longint'(r) >> (8 * off))
      & ((64'd1 << bits) - 1);
    if (sg && v >= (64'd1 << (bits - 1)))
      v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  task automatic model_reset();
    owner = 0; fin = 0; scnt = 0;
    e_valid = 0; e_we = 0; e_be = 0;
    e_addr = 0; e_wdata = 0; e_if = 0; e_d = 0;
  endtask

  task automatic model_step();
    bit dv;
    bit ti;
    logic [31:0] w;
    if (owner == 0) begin
      dv = d_req && !is_mis(d_size, d_addr);
      if (dv || if_req) begin
        ti = if_req && (!dv || scnt == SMAX);
        if (ti || !if_req) scnt = 0;
        else scnt = scnt + 1;
        e_valid = 1;
        if (ti) begin
          owner = 1; e_we = 0; e_be = 4'hf;
          e_addr = if_addr;
          grants_i++;
        end else begin
          owner = 2; e_we = d_we;
          e_addr = d_addr[31:2];
          l_off = int'(d_addr % 4);
          l_size = int'(d_size);
          l_sgn = d_signed; l_we = d_we;
          w = d_wdata;
          e_be = 4'hf;
          if (d_we) begin
            if (l_size == 0) begin
              e_be = 4'(1 << l_off);
              e_wdata = (w & 32'hff) * 32'h01010101;
            end else if (l_size == 1) begin
              e_be = 4'(3 << (l_off - l_off % 2));
              e_wdata = (w & 32'hffff) * 32'h00010001;
            end else begin
              e_wdata = w;
            end
          end
          grants_d++;
        end
      end
    end else if (!fin) begin
      if (mem_ready) begin
        e_valid = 0; fin = 1;
        if (owner == 1) e_if = mem_rdata;
        else if (!l_we)
          e_d = load_val(mem_rdata, l_off, l_size, l_sgn);
      end
    end else begin
      fin = 0; owner = 0;
    end
  endtask

  task automatic new_data();
    int r;
    d_we = 1'($urandom);
    d_signed = 1'($urandom);
    d_wdata = $urandom;
    d_addr = $urandom;
    r = $urandom_range(0, 15);
    if (r < 5) d_size = 2'd0;
    else if (r < 10) d_size = 2'd1;
    else if (r < 15 || sat) d_size = 2'd2;
    else d_size = 2'd3;
    if (sat || $urandom_range(0, 3) != 0) begin
      if (d_size == 2'd1) d_addr[0] = 1'b0;
      if (d_size == 2'd2) d_addr[1:0] = 2'b00;
    end
  endtask

  task automatic drive();
    int p;
    p = sat ? 100 : 60;
    if (!if_req || !ps_if) begin
      if_req = ($urandom_range(0, 99) < p);
      if_addr = 30'($urandom);
    end else if (!sat && $urandom_range(0, 99) < 2) begin
      if_req = 1'b0;
    end
    if (!d_req || !ps_d) begin
      d_req = ($urandom_range(0, 99) < p);
      new_data();
    end else if (!sat && $urandom_range(0, 99) < 2) begin
      d_req = 1'b0;
    end
    mem_ready = sat ? 1'b1 : ($urandom_range(0, 99) < 40);
    mem_rdata = $urandom;
  endtask

  task automatic check_all();
    bit m;
    m = is_mis(d_size, d_addr);
    ps_if = if_req && !(fin && owner == 1);
    ps_d = d_req && !(fin && owner == 2) && !m;
    chk("if_stall", 32'(if_stall), 32'(ps_if));
    chk("d_stall", 32'(d_stall), 32'(ps_d));
    chk("d_misalign", 32'(d_misalign), 32'(d_req && m));
    chk("mem_valid", 32'(mem_valid), 32'(e_valid));
    chk("if_rdata", if_rdata, e_if);
    chk("d_rdata", d_rdata, e_d);
    if (e_valid) begin
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_be", 32'(mem_be), 32'(e_be));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(mem_valid), 0);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_be"}, 32'(mem_be), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_misalign"}, 32'(d_misalign), 0);
  endtask

  initial begin
    int nrst;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
    d_size = 0; d_signed = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    sat = 0; ps_if = 0; ps_d = 0; nrst = 0;
    grants_i = 0; grants_d = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      sat = (cyc >= 2000 && cyc < 2600);
      if (((nrst == 0 && cyc >= 1200) ||
           (nrst == 1 && cyc >= 3200)) &&
          owner == 2 && !fin) begin
        nrst++;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        d_req = 1'b0; ps_d = 0;
        if_req = 1'b1; ps_if = 1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive();
      #1;
      check_all();
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    chk("reset_hit", 32'(nrst), 2);
    chk("grants_i_seen", 32'(grants_i > 50), 1);
    chk("grants_d_seen", 32'(grants_d > 50), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
